// File: rtl/pdm_output_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_output_stream
//  Purpose  : Converts a stream of unsigned PCM samples into a 1-bit PDM
//             bitstream using a first-order error-feedback modulator. Each
//             accepted sample is held for one window of OSR PDM bits; each
//             PDM bit lasts CLK_DIV clk cycles.
//  Ports    : clk        - system clock, all logic on the rising edge
//             rst_n      - synchronous active-low reset
//             enable     - 1 = modulate, 0 = idle
//             s_data     - unsigned PCM sample (0 .. 2^WIDTH-1)
//             s_valid    - s_data valid
//             s_ready    - holding register empty, a sample can be taken
//             pdm_out    - registered PDM bitstream
//             bit_tick   - one-cycle strobe on every PDM bit update
//             underflow  - one-cycle pulse when a window starts with no
//                          fresh sample waiting
//  Revision : 1.0 - initial release
// ============================================================================
module pdm_output_stream #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned OSR     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             pdm_out,
  output logic             bit_tick,
  output logic             underflow
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);
  localparam logic [WIDTH-1:0] FS       = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [WIDTH-1:0] error_q,     error_d;
  logic [WIDTH-1:0] cur_q,       cur_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic             pdm_q,       pdm_d;
  logic             tick_q,      tick_d;
  logic             unf_q,       unf_d;

  logic             w_tick;
  logic             w_win_start;
  logic [WIDTH-1:0] w_sample;
  logic             w_bit;
  logic [WIDTH:0]   w_err_hi;
  logic [WIDTH:0]   w_err_lo;
  logic [WIDTH-1:0] w_err_next;

  assign w_tick      = (div_cnt_q == DIV_LAST);
  assign w_win_start = (bit_cnt_q == '0);

  // A fresh sample is only swapped in at the first bit of a window;
  // otherwise (or when nothing is waiting) the current sample repeats.
  assign w_sample = (w_win_start && hold_full_q) ? hold_q : cur_q;

  // First-order modulator, intermediate arithmetic one bit wider than the
  // sample so the comparison result guarantees a result in 0..FS.
  assign w_bit    = (w_sample >= error_q);
  assign w_err_hi = {1'b0, error_q} + {1'b0, FS} - {1'b0, w_sample};
  assign w_err_lo = {1'b0, error_q} - {1'b0, w_sample};

  // The top bit can only be set if the selected branch would leave 0..FS;
  // clamp defensively rather than wrap.
  always_comb begin
    w_err_next = error_q;
    if (w_bit) begin
      w_err_next = w_err_hi[WIDTH] ? FS : w_err_hi[WIDTH-1:0];
    end else begin
      w_err_next = w_err_lo[WIDTH] ? '0 : w_err_lo[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      error_q     <= '0;
      cur_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      pdm_q       <= 1'b0;
      tick_q      <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      error_q     <= error_d;
      cur_q       <= cur_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      pdm_q       <= pdm_d;
      tick_q      <= tick_d;
      unf_q       <= unf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    error_d     = error_q;
    cur_d       = cur_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    pdm_d       = pdm_q;
    tick_d      = 1'b0;
    unf_d       = 1'b0;

    // Holding register load. s_ready is simply !hold_full_q, so a window
    // start consuming the held value in this cycle cannot also accept.
    if (s_valid && !hold_full_q) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        error_d   = '0;
        cur_d     = '0;
        pdm_d     = 1'b0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Leaving RUN discards any tick falling in this cycle.
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          error_d   = '0;
          cur_d     = '0;
          pdm_d     = 1'b0;
        end else begin
          div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
          if (w_tick) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            pdm_d     = w_bit;
            error_d   = w_err_next;
            tick_d    = 1'b1;
            if (w_win_start) begin
              if (hold_full_q) begin
                cur_d       = hold_q;
                hold_full_d = 1'b0;
              end else begin
                unf_d = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_ready   = ~hold_full_q;
  assign pdm_out   = pdm_q;
  assign bit_tick  = tick_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: doc/pdm_output_stream.md
PDM_OUTPUT_STREAM -- requirements
Module: pdm_output_stream

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the sample width; legal range >= 2; full scale FS = 2^WIDTH-1.
REQ-002 Parameter CLK_DIV, default 4, SHALL set the clk cycles per PDM bit; legal range >= 1.
REQ-003 Parameter OSR, default 64, SHALL set the PDM bits per input sample; legal range >= 1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low; one clock domain.
REQ-006 enable  input  1  high = modulate; low = idle.
REQ-007 s_data  input  WIDTH  unsigned PCM sample; 0 = silence-low, FS = all-ones.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  holding register empty; a sample can be accepted.
REQ-010 pdm_out  output  1  registered PDM bitstream.
REQ-011 bit_tick  output  1  one-cycle strobe on every PDM bit update.
REQ-012 underflow  output  1  one-cycle pulse when a sample window starts with the holding register empty.

Function
REQ-013 Holding register: s_ready SHALL equal NOT hold_full, driven from a register with no combinational path from s_valid.
REQ-014 Transfer: when s_valid AND s_ready, s_data SHALL be stored and hold_full SHALL be set on the next edge; no bypass; accepted in IDLE and RUN.
REQ-015 State machine: IDLE -> RUN when enable=1; RUN -> IDLE when enable=0, effective on the next edge.
REQ-016 IDLE: div_cnt, bit_cnt, error, cur_sample SHALL be 0; pdm_out=0; bit_tick=0; underflow=0; holding register contents and hold_full SHALL be retained.
REQ-017 Divider: div_cnt SHALL count 0..CLK_DIV-1 and wrap in RUN; a tick SHALL occur in each cycle where div_cnt==CLK_DIV-1.
REQ-018 Timing: with CLK_DIV=1, every RUN cycle is a tick; the first tick SHALL occur in the CLK_DIV-th RUN cycle.
REQ-019 Window: bit_cnt SHALL advance by 1 per tick and wrap after OSR-1 -> 0.
REQ-020 Window-start tick (bit_cnt==0), hold_full=1: the sample used SHALL be the held value; cur_sample <= held value; hold_full cleared.
REQ-021 Window-start tick, hold_full=0: the sample used SHALL be cur_sample (repeat), and underflow SHALL pulse in the cycle after that tick.
REQ-022 Other ticks SHALL use cur_sample.
REQ-023 Modulator, per tick, with sample d: if d >= error then pdm_out <= 1 and error <= error + FS - d; else pdm_out <= 0 and error <= error - d.
REQ-024 Error SHALL be WIDTH bits unsigned; the update SHALL never wrap (range 0..FS); intermediate sums SHALL be computed at WIDTH+1 bits.
REQ-025 pdm_out and bit_tick SHALL update on the edge ending the tick cycle and hold between ticks.
REQ-026 Density: over any FS consecutive ticks with constant d, the count of ones SHALL be d +/- 1.
REQ-027 Simultaneous events: a window-start consume and an s_valid arrival in the same cycle SHALL not accept the sample; the sample is accepted on the next cycle (s_ready=1 then).
REQ-028 Simultaneous events: an enable drop on a tick cycle SHALL discard that tick; no pdm_out update and no underflow pulse.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state IDLE, every counter, error, cur_sample and hold_full to 0, pdm_out=0, bit_tick=0, underflow=0, s_ready=1.
REQ-030 Reset mid-operation SHALL take effect in the same edge and drop any held sample.

Verification
REQ-031 WIDTH=8, CLK_DIV=1, OSR=255: preload d=255, enable -> pdm_out all ones; no underflow for 255 ticks.
REQ-032 d=0, same setup -> pdm_out = 1 on the first tick, then 0 for the remaining 254 ticks; error holds at 255.
REQ-033 d=128 streamed every window -> ones per 255-tick window = 128 +/- 1; s_ready falls and rises once per window.
REQ-034 CLK_DIV=4, OSR=8, one sample then none -> bit_tick every 4 cycles; underflow pulses at the start of window 2; the prior sample repeats.
REQ-035 Drop enable mid-window, then re-enable -> pdm_out=0 and error=0 in IDLE; held sample retained; modulation restarts at bit_cnt 0.
REQ-036 rst_n=0 mid-run with hold_full=1 -> all outputs per REQ-029 on the next edge; s_ready=1.
